// File: rtl/lcd_capture.sv
// Gameboy LCD stream capture: syncs the pixel stream, packs 2bpp pixels four per byte,
// queues {addr,data} in a small FIFO for a valid/ready framebuffer port. Optional CRC: LCD_CAPTURE_CRC_EN.
module lcd_capture #(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 144,
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = 13
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [1:0]    pixel_data,
  input  logic          pixel_clock,
  input  logic          pixel_latch,
  input  logic          vsync,
  output logic [AW-1:0] fb_addr,
  output logic [7:0]    fb_data,
  output logic          fb_we,
  input  logic          fb_ready,
  input  logic          clear_status,
  output logic          frame_done,
  output logic          overflow,
  output logic          line_err,
  output logic          busy,
  output logic [15:0]   frame_crc
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(HEIGHT + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] COL_MAX    = CW'(WIDTH);
  localparam logic [RW-1:0] ROW_LAST   = RW'(HEIGHT - 1);
  localparam logic [AW-1:0] LINE_BYTES = AW'(WIDTH / 4);
  localparam logic [NW-1:0] FIFO_FULL  = NW'(FIFO_DEPTH);

  logic          pclk_r, pclk_d_r, plat_r, plat_d_r, vs_r, vs_d_r;
  logic [1:0]    pdata_r;
  logic          pix_edge_s, lat_edge_s, vs_edge_s, frame_end_s;
  logic          active_r, pack_valid_r, frame_done_r;
  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;
  logic [AW-1:0] byte_addr_r, line_base_r, pack_addr_r;
  logic [5:0]    sh_r;
  logic [7:0]    pack_byte_r;
  logic          overflow_r, line_err_r, busy_r, line_err_set_s;
  logic [AW-1:0] mem_addr_r [FIFO_DEPTH];
  logic [7:0]    mem_data_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [NW-1:0] count_r;
  logic          push_s, pop_s, full_s, accept_s, drop_s;

  // Single-register sync of the stream plus a delayed copy for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pclk_r   <= 1'b0; pclk_d_r <= 1'b0;
      plat_r   <= 1'b0; plat_d_r <= 1'b0;
      vs_r     <= 1'b0; vs_d_r   <= 1'b0;
      pdata_r  <= 2'b00;
    end else begin
      pclk_r   <= pixel_clock; pclk_d_r <= pclk_r;
      plat_r   <= pixel_latch; plat_d_r <= plat_r;
      vs_r     <= vsync;       vs_d_r   <= vs_r;
      pdata_r  <= pixel_data;
    end
  end

  assign pix_edge_s  = pclk_r & ~pclk_d_r;
  assign lat_edge_s  = plat_r & ~plat_d_r;
  assign vs_edge_s   = vs_r & ~vs_d_r;
  assign frame_end_s = active_r & ~vs_edge_s & lat_edge_s & (row_r == ROW_LAST);
  // Short lines leave the address at the next line base, so a line never spills into its neighbour.
  assign line_err_set_s = active_r & ~vs_edge_s &
                          ((lat_edge_s & (col_r != COL_MAX)) |
                           (~lat_edge_s & pix_edge_s & (col_r == COL_MAX)));

  // Line/frame tracking and pixel packing; vsync has priority over latch, latch over pixel.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active_r     <= 1'b0;
      col_r        <= '0;
      row_r        <= '0;
      byte_addr_r  <= '0;
      line_base_r  <= '0;
      sh_r         <= 6'd0;
      pack_valid_r <= 1'b0;
      pack_byte_r  <= 8'd0;
      pack_addr_r  <= '0;
      frame_done_r <= 1'b0;
    end else begin
      pack_valid_r <= 1'b0;
      frame_done_r <= 1'b0;
      if (vs_edge_s) begin
        active_r    <= 1'b1;
        col_r       <= '0;
        row_r       <= '0;
        byte_addr_r <= '0;
        line_base_r <= '0;
        sh_r        <= 6'd0;
      end else if (active_r && lat_edge_s) begin
        col_r       <= '0;
        sh_r        <= 6'd0;
        line_base_r <= line_base_r + LINE_BYTES;
        byte_addr_r <= line_base_r + LINE_BYTES;
        row_r       <= row_r + RW'(1);
        if (row_r == ROW_LAST) begin
          active_r     <= 1'b0;
          frame_done_r <= 1'b1;
        end
      end else if (active_r && pix_edge_s && (col_r != COL_MAX)) begin
        col_r <= col_r + CW'(1);
        if (col_r[1:0] == 2'd3) begin
          pack_valid_r <= 1'b1;
          pack_byte_r  <= {sh_r, pdata_r};
          pack_addr_r  <= byte_addr_r;
          byte_addr_r  <= byte_addr_r + AW'(1);
        end else begin
          sh_r <= {sh_r[3:0], pdata_r};
        end
      end
    end
  end

  assign push_s   = pack_valid_r;
  assign pop_s    = (count_r != '0) & fb_ready;
  assign full_s   = (count_r == FIFO_FULL);
  assign accept_s = push_s & (~full_s | pop_s);
  assign drop_s   = push_s & full_s & ~pop_s;

  // Write FIFO; a full FIFO still accepts when the head leaves in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_addr_r[i] <= '0;
        mem_data_r[i] <= 8'd0;
      end
    end else begin
      if (accept_s) begin
        mem_addr_r[wr_ptr_r] <= pack_addr_r;
        mem_data_r[wr_ptr_r] <= pack_byte_r;
        wr_ptr_r             <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({accept_s, pop_s})
        2'b10:   count_r <= count_r + NW'(1);
        2'b01:   count_r <= count_r - NW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign fb_we   = (count_r != '0);
  assign fb_addr = mem_addr_r[rd_ptr_r];
  assign fb_data = mem_data_r[rd_ptr_r];

  // Sticky status flags (a new event beats clear_status) and the busy window.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_r <= 1'b0;
      line_err_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      if (drop_s)            overflow_r <= 1'b1;
      else if (clear_status) overflow_r <= 1'b0;
      if (line_err_set_s)    line_err_r <= 1'b1;
      else if (clear_status) line_err_r <= 1'b0;
      if (vs_edge_s)                                          busy_r <= 1'b1;
      else if (!active_r && count_r == '0 && !pack_valid_r)   busy_r <= 1'b0;
    end
  end

  assign frame_done = frame_done_r;
  assign overflow   = overflow_r;
  assign line_err   = line_err_r;
  assign busy       = busy_r;

`ifdef LCD_CAPTURE_CRC_EN
  logic [15:0] crc_r, frame_crc_r, crc_next_s;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int b = 7; b >= 0; b--) begin
      fb = c[15] ^ data[b];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  assign crc_next_s = pack_valid_r ? crc16_byte(crc_r, pack_byte_r) : crc_r;

  // Running CRC covers every packed byte, dropped ones included.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      crc_r       <= 16'hFFFF;
      frame_crc_r <= 16'h0000;
    end else begin
      if (vs_edge_s) crc_r <= 16'hFFFF;
      else           crc_r <= crc_next_s;
      if (frame_end_s) frame_crc_r <= crc_next_s;
    end
  end

  assign frame_crc = frame_crc_r;
`else
  assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_lcd_capture.sv
// Directed bench for lcd_capture: model pushes expected writes into a scoreboard queue,
// a negedge monitor pops and compares them as the framebuffer port transfers.
module tb_lcd_capture;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  pixel_data = 2'b00;
  logic        pixel_clock = 1'b0, pixel_latch = 1'b0, vsync = 1'b0;
  logic [12:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_we;
  logic        fb_ready = 1'b1;
  logic        clear_status = 1'b0;
  logic        frame_done, overflow, line_err, busy;
  logic [15:0] frame_crc;

  lcd_capture #(.WIDTH(160), .HEIGHT(144), .FIFO_DEPTH(4), .AW(13)) dut (
    .clock(clock), .reset(reset), .pixel_data(pixel_data), .pixel_clock(pixel_clock),
    .pixel_latch(pixel_latch), .vsync(vsync), .fb_addr(fb_addr), .fb_data(fb_data),
    .fb_we(fb_we), .fb_ready(fb_ready), .clear_status(clear_status),
    .frame_done(frame_done), .overflow(overflow), .line_err(line_err), .busy(busy),
    .frame_crc(frame_crc)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic [12:0] a; logic [7:0] d; } exp_t;
  exp_t        sb_q[$];
  int          n_cmp = 0, n_fail = 0, n_writes = 0, n_fd = 0;
  logic [12:0] last_addr = 13'd0;
  int          m_col = 0, m_row = 0, budget = -1;
  logic [5:0]  m_sh = 6'd0;
  logic        m_active = 1'b0;
  int          w0;
  logic [15:0] exp_crc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  // Scoreboard monitor: a transfer happens at the next posedge when fb_we && fb_ready.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && fb_we && fb_ready) begin
      n_writes++;
      last_addr = fb_addr;
      if (sb_q.size() == 0) check("sb_underrun", 32'(sb_q.size()), 32'd1);
      else begin
        e = sb_q.pop_front();
        check("wr_addr", 32'(fb_addr), 32'(e.a));
        check("wr_data", 32'(fb_data), 32'(e.d));
      end
    end
    if (frame_done) n_fd++;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pixel_rise(input logic [1:0] v);
    pixel_data  = v;
    pixel_clock = 1'b1;
    if (m_active && m_col < 160) begin
      if (m_col % 4 == 3) begin
        if (budget != 0) begin
          sb_q.push_back({13'(m_row * 40 + m_col / 4), m_sh, v});
          if (budget > 0) budget--;
        end
      end else m_sh = {m_sh[3:0], v};
      m_col++;
    end
  endtask

  task automatic pixel(input logic [1:0] v);
    pixel_rise(v);
    tick();
    pixel_clock = 1'b0;
    tick();
  endtask

  task automatic latch();
    pixel_latch = 1'b1;
    tick();
    pixel_latch = 1'b0;
    tick();
    if (m_active) begin
      m_col = 0;
      m_sh  = 6'd0;
      m_row++;
      if (m_row == 144) m_active = 1'b0;
    end
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
    m_active = 1'b1; m_col = 0; m_row = 0; m_sh = 6'd0;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (sb_q.size() != 0 && k < 200) begin tick(); k++; end
    tick(); tick();
    check(tag, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic line_rand(input int n);
    for (int c = 0; c < n; c++) pixel(2'($urandom_range(0, 3)));
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_fb_we", 32'(fb_we), 32'd0);
    check("rst_fb_addr", 32'(fb_addr), 32'd0);
    check("rst_fb_data", 32'(fb_data), 32'd0);
    check("rst_status", {28'd0, frame_done, overflow, line_err, busy}, 32'd0);
    check("rst_crc", 32'(frame_crc), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Line of all-3 pixels, with the 3-clock latency check on the first byte
    vsync_pulse();
    check("busy_after_vsync", 32'(busy), 32'd1);
    for (int c = 0; c < 3; c++) pixel(2'd3);
    pixel_rise(2'd3);
    tick();
    pixel_clock = 1'b0;
    check("lat_clk1", 32'(fb_we), 32'd0);
    tick();
    check("lat_clk2", 32'(fb_we), 32'd0);
    tick();
    check("lat_clk3", 32'(fb_we), 32'd1);
    for (int c = 4; c < 160; c++) pixel(2'd3);
    latch();
    drain("drain_line0");
    check("line0_writes", 32'(n_writes), 32'd40);
    check("line0_err", 32'(line_err), 32'd0);

    // Overflow: fb_ready low for a whole line keeps only the first 4 bytes
    fb_ready = 1'b0;
    budget = 4;
    w0 = n_writes;
    line_rand(160);
    latch();
    tick();
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_fifo_full", 32'(fb_we), 32'd1);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    check("ovf_clear", 32'(overflow), 32'd0);
    fb_ready = 1'b1;
    drain("drain_ovf");
    check("ovf_writes", 32'(n_writes - w0), 32'd4);
    budget = -1;

    // Short line sets line_err; next line starts at address 40
    vsync_pulse();
    line_rand(158);
    latch();
    check("short_line_err", 32'(line_err), 32'd1);
    line_rand(4);
    drain("drain_short");
    check("short_next_addr", 32'(last_addr), 32'd40);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    check("lerr_clear", 32'(line_err), 32'd0);
    line_rand(156);
    latch();
    // Excess pixel on row 2
    line_rand(161);
    tick();
    check("excess_line_err", 32'(line_err), 32'd1);
    latch();
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    for (int r = 3; r < 10; r++) begin line_rand(160); latch(); end
    line_rand(8);
    drain("drain_row10");
    check("row10_addr", 32'(last_addr), 32'd401);
    check("row10_lerr", 32'(line_err), 32'd0);

    // Vsync mid-frame (row 10, col 8) then a full col%4 frame
    vsync_pulse();
    w0 = n_writes;
    n_fd = 0;
    for (int r = 0; r < 144; r++) begin
      for (int c = 0; c < 160; c++) begin
        pixel(2'(c % 4));
        if (r == 0 && c == 3) begin
          drain("drain_first");
          check("frame_first_addr", 32'(last_addr), 32'd0);
        end
      end
      if (r == 143) check("no_early_done", 32'(n_fd), 32'd0);
      latch();
    end
    tick();
    check("frame_done_once", 32'(n_fd), 32'd1);
    begin
      int k = 0;
      while (busy && k < 100) begin tick(); k++; end
    end
    check("busy_fall", 32'(busy), 32'd0);
    check("frame_writes", 32'(n_writes - w0), 32'd5760);
    check("frame_last_addr", 32'(last_addr), 32'd5759);
    check("frame_sb_empty", 32'(sb_q.size()), 32'd0);
`ifdef LCD_CAPTURE_CRC_EN
    exp_crc = 16'hFFFF;
    for (int i = 0; i < 5760; i++) exp_crc = crc_upd(exp_crc, 8'h1B);
`else
    exp_crc = 16'h0000;
`endif
    check("frame_crc", 32'(frame_crc), 32'(exp_crc));

    // Pixels after frame_done are ignored until the next vsync
    w0 = n_writes;
    line_rand(8);
    latch();
    tick(); tick();
    check("post_frame_writes", 32'(n_writes - w0), 32'd0);
    check("post_frame_done", 32'(n_fd), 32'd1);

    // Asynchronous reset mid-line; capture waits for the next vsync
    vsync_pulse();
    line_rand(2);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_fb_we", 32'(fb_we), 32'd0);
    tick();
    reset = 1'b0;
    m_active = 1'b0;
    w0 = n_writes;
    line_rand(8);
    tick(); tick(); tick();
    check("arst_no_capture", 32'(n_writes - w0), 32'd0);
    check("arst_idle_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
